// File: rtl/mips150_instr_encoder_if.sv
// Request/IMEM-write bundle for the MIPS150 instruction encoder.
// master = program builder / IMEM side, slave = encoder.
interface mips150_instr_encoder_if #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_value;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic              err;
    logic [CNT_W-1:0]  words_written;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
               addr_load, addr_value, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_din, err, words_written, err_count
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
               addr_load, addr_value, imem_ready,
        output in_ready, imem_we, imem_addr, imem_din, err, words_written, err_count
    );
endinterface

// File: rtl/mips150_instr_encoder.sv
// Encodes abstract op requests into MIPS-I machine words and streams them into IMEM
// through a single registered output stage with valid/ready on both sides.
module mips150_instr_encoder #(
    parameter int          ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    mips150_instr_encoder_if.slave bus
);
    typedef enum logic [5:0] {
        OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_J, OP_JAL
    } op_e;

    typedef enum logic {EMPTY, FULL} state_e;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic              err_q;
    logic [CNT_W-1:0]  wcnt_q, ecnt_q;

    logic        legal;
    logic [31:0] word;
    logic        wr_done, ready, accept;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // Field forcing keeps every emitted word canonical so decode round-trips exactly.
    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (bus.in_op)
            OP_ADDU:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21);
            OP_SUBU:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h23);
            OP_AND:   word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24);
            OP_OR:    word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25);
            OP_XOR:   word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h26);
            OP_NOR:   word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h27);
            OP_SLT:   word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A);
            OP_SLTU:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2B);
            OP_SLL:   word = r_word(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00);
            OP_SRL:   word = r_word(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h02);
            OP_SRA:   word = r_word(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h03);
            OP_SLLV:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h04);
            OP_SRLV:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h06);
            OP_SRAV:  word = r_word(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h07);
            OP_JR:    word = r_word(bus.in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
            OP_JALR:  word = r_word(bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'h09);
            OP_ADDIU: word = i_word(6'h09, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_SLTI:  word = i_word(6'h0A, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_SLTIU: word = i_word(6'h0B, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_ANDI:  word = i_word(6'h0C, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_ORI:   word = i_word(6'h0D, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_XORI:  word = i_word(6'h0E, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_LUI:   word = i_word(6'h0F, 5'd0, bus.in_rt, bus.in_imm);
            OP_LB:    word = i_word(6'h20, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_LH:    word = i_word(6'h21, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_LW:    word = i_word(6'h23, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_LBU:   word = i_word(6'h24, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_LHU:   word = i_word(6'h25, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_SB:    word = i_word(6'h28, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_SH:    word = i_word(6'h29, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_SW:    word = i_word(6'h2B, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_BEQ:   word = i_word(6'h04, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_BNE:   word = i_word(6'h05, bus.in_rs, bus.in_rt, bus.in_imm);
            OP_BLEZ:  word = i_word(6'h06, bus.in_rs, 5'd0, bus.in_imm);
            OP_BGTZ:  word = i_word(6'h07, bus.in_rs, 5'd0, bus.in_imm);
            OP_BLTZ:  word = i_word(6'h01, bus.in_rs, 5'h00, bus.in_imm);
            OP_BGEZ:  word = i_word(6'h01, bus.in_rs, 5'h01, bus.in_imm);
            OP_J:     word = {6'h02, bus.in_target};
            OP_JAL:   word = {6'h03, bus.in_target};
            default:  legal = 1'b0;
        endcase
    end

    assign wr_done = (state_q == FULL) && bus.imem_ready;
    assign ready   = (state_q == EMPTY) || wr_done;
    assign accept  = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        if (accept)       state_d = legal ? FULL : EMPTY;
        else if (wr_done) state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // ptr_q is the next free word; addr_q is the word currently held for IMEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= BASE;
            addr_q <= BASE;
            din_q  <= '0;
            err_q  <= 1'b0;
            wcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            err_q <= accept && !legal;
            if (accept && legal) begin
                addr_q <= ptr_q;
                din_q  <= word;
                ptr_q  <= ptr_q + ADDR_W'(1);
            end else if (bus.addr_load && state_q == EMPTY && !accept) begin
                ptr_q <= bus.addr_value;
            end
            if (wr_done && wcnt_q != '1)           wcnt_q <= wcnt_q + CNT_W'(1);
            if (accept && !legal && ecnt_q != '1)  ecnt_q <= ecnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready      = ready;
    assign bus.imem_we       = (state_q == FULL);
    assign bus.imem_addr     = addr_q;
    assign bus.imem_din      = din_q;
    assign bus.err           = err_q;
    assign bus.words_written = wcnt_q;
    assign bus.err_count     = ecnt_q;
endmodule

// File: tb/tb_mips150_instr_encoder.sv
// Directed + randomized bench for mips150_instr_encoder against a table-driven
// encoding model and an expected-write queue.
module tb_mips150_instr_encoder;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips150_instr_encoder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    mips150_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // R-type funct for ops 0..15; primary opcode for ops 16..38.
    logic [5:0] rfn  [16] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                              6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09};
    logic [5:0] iopc [23] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20,
                              6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h04,
                              6'h05, 6'h06, 6'h07, 6'h01, 6'h01, 6'h02, 6'h03};

    function automatic logic [31:0] ref_enc(input int op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [4:0] sh, input logic [15:0] imm,
                                            input logic [25:0] tgt);
        if (op < 16) begin
            if (op >= 8 && op <= 10) rs = 5'd0;
            else                     sh = 5'd0;
            if (op == 14) begin rt = 5'd0; rd = 5'd0; end
            if (op == 15) rt = 5'd0;
            return {6'd0, rs, rt, rd, sh, rfn[op]};
        end
        if (op >= 37) return {iopc[op-16], tgt};
        if (op == 22) rs = 5'd0;
        if (op == 33 || op == 34 || op == 35) rt = 5'd0;
        if (op == 36) rt = 5'd1;
        return {iopc[op-16], rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.addr_load  = 1'b0;
        bus.addr_value = '0;
    endtask

    task automatic req(input int op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
        bus.in_valid  = 1'b1;
        bus.in_op     = op[5:0];
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_shamt  = sh;
        bus.in_imm    = imm;
        bus.in_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        bus.imem_ready = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, ".imem_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'd0);
        chk({tag, ".imem_din"}, bus.imem_din, 32'd0);
        chk({tag, ".err"}, 32'(bus.err), 32'd0);
        chk({tag, ".words"}, 32'(bus.words_written), 32'd0);
        chk({tag, ".errcnt"}, 32'(bus.err_count), 32'd0);
    endtask

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] ent;
    logic [31:0]        held_din;
    int mptr, n_wr, n_err, rop;
    bit hs, wr, exp_err;

    initial begin
        idle();
        bus.imem_ready = 1'b1;
        bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0;
        #2;
        chk_reset_state("reset");
        do_reset();
        chk_reset_state("post_reset");

        // ADDU, one-cycle latency
        req(0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
        cyc();
        idle();
        chk("addu.we", 32'(bus.imem_we), 32'd1);
        chk("addu.addr", 32'(bus.imem_addr), 32'd0);
        chk("addu.din", bus.imem_din, 32'h00221821);

        // ADDIU then LUI back-to-back
        do_reset();
        req(16, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
        cyc();
        chk("addiu.din", bus.imem_din, 32'h24081234);
        chk("addiu.addr", 32'(bus.imem_addr), 32'd0);
        req(22, 5'd7, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        #1;
        chk("lui.in_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        idle();
        chk("lui.din", bus.imem_din, 32'h3C01FFFF);
        chk("lui.addr", 32'(bus.imem_addr), 32'd1);
        cyc();
        chk("b2b.words", 32'(bus.words_written), 32'd2);
        chk("b2b.we_idle", 32'(bus.imem_we), 32'd0);

        // BGEZ ignores in_rt; J
        do_reset();
        req(36, 5'd4, 5'd9, 5'd0, 5'd0, 16'hFFFE, 26'h0);
        cyc();
        chk("bgez.din", bus.imem_din, 32'h0481FFFE);
        req(37, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
        cyc();
        idle();
        chk("j.din", bus.imem_din, 32'h08000100);

        // stall with register full, then reset mid-stall
        do_reset();
        req(31, 5'd1, 5'd2, 5'd0, 5'd0, 16'h3, 26'h0);
        cyc();
        held_din = bus.imem_din;
        chk("stall.din0", held_din, 32'h10220003);
        bus.imem_ready = 1'b0;
        req(0, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
            cyc();
            chk("stall.we", 32'(bus.imem_we), 32'd1);
            chk("stall.din", bus.imem_din, held_din);
            chk("stall.addr", 32'(bus.imem_addr), 32'd0);
            chk("stall.words", 32'(bus.words_written), 32'd0);
        end
        rst = 1'b1;
        #2;
        chk_reset_state("rst_mid_stall");
        do_reset();

        // illegal op consumed, not written
        req(45, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        #1;
        chk("illegal.in_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        idle();
        chk("illegal.we", 32'(bus.imem_we), 32'd0);
        chk("illegal.err", 32'(bus.err), 32'd1);
        chk("illegal.errcnt", 32'(bus.err_count), 32'd1);
        cyc();
        chk("illegal.err_pulse", 32'(bus.err), 32'd0);
        req(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        cyc();
        idle();
        chk("after_illegal.addr", 32'(bus.imem_addr), 32'd0);
        chk("after_illegal.din", bus.imem_din, 32'h00221821);

        // addr_load coinciding with accept is dropped
        do_reset();
        req(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        bus.addr_load = 1'b1;
        bus.addr_value = 12'h055;
        cyc();
        idle();
        chk("load_vs_accept.addr", 32'(bus.imem_addr), 32'd0);
        cyc();
        req(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        cyc();
        idle();
        chk("load_vs_accept.next", 32'(bus.imem_addr), 32'd1);

        // addr_load then two SW wrapping the pointer
        do_reset();
        bus.addr_load = 1'b1;
        bus.addr_value = 12'hFFF;
        cyc();
        idle();
        req(30, 5'd29, 5'd31, 5'd0, 5'd0, 16'h4, 26'h0);
        cyc();
        chk("sw0.addr", 32'(bus.imem_addr), 32'hFFF);
        chk("sw0.din", bus.imem_din, 32'hAFBF0004);
        req(30, 5'd29, 5'd31, 5'd0, 5'd0, 16'h8, 26'h0);
        cyc();
        idle();
        chk("sw1.addr", 32'(bus.imem_addr), 32'h000);
        chk("sw1.din", bus.imem_din, 32'hAFBF0008);
        chk("sw.words", 32'(bus.words_written), 32'd1);

        // randomized traffic against the expected-write queue
        do_reset();
        mptr = 0; n_wr = 0; n_err = 0;
        for (int n = 0; n < 600; n++) begin
            rop = ($urandom % 8 == 0) ? 39 + int'($urandom % 25) : int'($urandom % 39);
            if ($urandom % 4 != 0)
                req(rop, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    16'($urandom), 26'($urandom));
            else
                bus.in_valid = 1'b0;
            bus.imem_ready = ($urandom % 3 != 0);
            @(negedge clk);
            chk("rnd.imem_we", 32'(bus.imem_we), 32'(exp_q.size() != 0));
            chk("rnd.in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0 || bus.imem_ready));
            hs = bus.in_valid && bus.in_ready;
            wr = bus.imem_we && bus.imem_ready;
            if (wr) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk("rnd.spurious_write", 32'd1, 32'd0);
                end else begin
                    ent = exp_q.pop_front();
                    chk("rnd.addr", 32'(bus.imem_addr), 32'(ent[ADDR_W+31:32]));
                    chk("rnd.din", bus.imem_din, ent[31:0]);
                end
            end
            exp_err = hs && (rop >= 39);
            if (hs && rop < 39) begin
                exp_q.push_back({ADDR_W'(mptr), ref_enc(rop, bus.in_rs, bus.in_rt, bus.in_rd,
                                 bus.in_shamt, bus.in_imm, bus.in_target)});
                mptr = (mptr + 1) % (1 << ADDR_W);
            end
            if (exp_err) n_err++;
            cyc();
            chk("rnd.err", 32'(bus.err), 32'(exp_err));
            chk("rnd.words", 32'(bus.words_written), 32'((n_wr > SAT) ? SAT : n_wr));
            chk("rnd.errcnt", 32'(bus.err_count), 32'((n_err > SAT) ? SAT : n_err));
        end
        idle();
        bus.imem_ready = 1'b1;
        cyc();
        cyc();
        chk("rnd.drained_we", 32'(bus.imem_we), 32'd0);
        chk("rnd.sat_words", 32'(bus.words_written), 32'(SAT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
